// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Definitions shared by the memory stage and its access FSM:
//   dtype_e    - destination register file encoding (P / R / F)
//   mm_state_e - memory access FSM state encoding
//   ex_mm_t    - EX/MM pipeline register bundle (everything except the
//                destination index, whose width is a module parameter)
//   is_misaligned - word alignment test on the low address bits
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        DT_P = 2'b00,
        DT_R = 2'b01,
        DT_F = 2'b10
    } dtype_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_FAULT  = 2'b10
    } mm_state_e;

    typedef struct packed {
        logic        valid;
        logic        load;
        logic        store;
        logic        wb_en;
        logic [1:0]  dtype;
        logic        res_p;
        logic [31:0] res_i;
        logic [31:0] res_f;
        logic [31:0] wdata;
    } ex_mm_t;

    // Only the two low address bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/mm_access_fsm.sv
// -----------------------------------------------------------------------------
// mm_access_fsm
// Data-memory access sequencer for the memory stage. Issues one req/ack
// transaction per aligned load/store held in the EX/MM register, counts wait
// cycles, and raises a one-cycle fault on timeout or misalignment.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_op_valid        EX/MM register holds a valid load or store
//   i_store           that op is a store
//   i_addr, i_wdata   address and store data from the EX/MM register
//   i_ack             memory access complete
//   o_req, o_we       memory request / write enable
//   o_addr, o_wdata   memory address / write data
//   o_busy            stall request for the upstream stages
//   o_fault           one-cycle fault pulse (misaligned or timeout)
// -----------------------------------------------------------------------------
module mm_access_fsm
    import core_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_op_valid,
    input  logic        i_store,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ack,
    output logic        o_req,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_busy,
    output logic        o_fault
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    mm_state_e          r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_misaligned;
    logic               w_start;

    assign w_misaligned = is_misaligned(i_addr[1:0]);
    // An aligned op waiting in IDLE starts an access on the next edge.
    assign w_start      = i_op_valid & ~w_misaligned;
    assign w_cnt_inc    = r_wait_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_ACCESS;
                        r_wait_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle beats the timeout.
                    if (i_ack) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address and data come straight from the EX/MM register, which holds
    // while the access is outstanding, so they stay stable until ack/timeout.
    assign o_req   = (r_state == ST_ACCESS);
    assign o_we    = (r_state == ST_ACCESS) & i_store;
    assign o_addr  = i_addr;
    assign o_wdata = i_wdata;

    assign o_busy  = ((r_state == ST_ACCESS) & ~i_ack)
                   | ((r_state == ST_IDLE) & w_start);

    // A misaligned op never leaves IDLE; it faults in the cycle it sits in
    // the EX/MM register and retires on the following edge.
    assign o_fault = (r_state == ST_FAULT)
                   | ((r_state == ST_IDLE) & i_op_valid & w_misaligned);

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage core: EX/MM pipeline register, forwarding of
// the registered execution results, data-memory access via mm_access_fsm,
// and the MM/WB register feeding writeback.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   ex_valid/ex_busy               execution stage handshake
//   ex_load/ex_store/ex_wb_en      instruction class and write enable
//   ex_dtype/ex_dest               destination file and index
//   result_P/result_I/result_F     execution results (result_I = address)
//   Wdata                          store data
//   pval_mm/rval_mm/fval_mm        forwarding from the EX/MM register
//   mm_busy                        stall request to upstream stages
//   dmem_*                         data memory req/ack interface
//   wb_valid/wb_dtype/wb_dest/wb_data  MM/WB register
//   mem_fault                      one-cycle fault pulse
// -----------------------------------------------------------------------------
module mem_stage
    import core_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_busy,
    input  logic             ex_load,
    input  logic             ex_store,
    input  logic             ex_wb_en,
    input  logic [1:0]       ex_dtype,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             result_P,
    input  logic [31:0]      result_I,
    input  logic [31:0]      result_F,
    input  logic [31:0]      Wdata,
    output logic             pval_mm,
    output logic [31:0]      rval_mm,
    output logic [31:0]      fval_mm,
    output logic             mm_busy,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ack,
    input  logic [31:0]      dmem_rdata,
    output logic             wb_valid,
    output logic [1:0]       wb_dtype,
    output logic [REG_W-1:0] wb_dest,
    output logic [31:0]      wb_data,
    output logic             mem_fault
);

    ex_mm_t             r_mm;
    logic [REG_W-1:0]   r_mm_dest;

    logic               r_wb_valid;
    logic [1:0]         r_wb_dtype;
    logic [REG_W-1:0]   r_wb_dest;
    logic [31:0]        r_wb_data;

    logic               w_mem_op;
    logic               w_busy;
    logic               w_fault;
    logic               w_retire;
    logic [31:0]        w_wb_data;

    // ---------------- EX/MM register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mm      <= '0;
            r_mm_dest <= '0;
        end else if (!w_busy) begin
            r_mm.valid <= ex_valid & ~ex_busy;
            r_mm.load  <= ex_load;
            r_mm.store <= ex_store;
            r_mm.wb_en <= ex_wb_en;
            r_mm.dtype <= ex_dtype;
            r_mm.res_p <= result_P;
            r_mm.res_i <= result_I;
            r_mm.res_f <= result_F;
            r_mm.wdata <= Wdata;
            r_mm_dest  <= ex_dest;
        end
    end

    assign w_mem_op = r_mm.valid & (r_mm.load | r_mm.store);

    // ---------------- Access FSM ----------------
    mm_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_op_valid (w_mem_op),
        .i_store    (r_mm.store),
        .i_addr     (r_mm.res_i),
        .i_wdata    (r_mm.wdata),
        .i_ack      (dmem_ack),
        .o_req      (dmem_req),
        .o_we       (dmem_we),
        .o_addr     (dmem_addr),
        .o_wdata    (dmem_wdata),
        .o_busy     (w_busy),
        .o_fault    (w_fault)
    );

    // ---------------- WB mux and MM/WB register ----------------
    assign w_retire = r_mm.valid & ~w_busy;

    always_comb begin
        w_wb_data = r_mm.res_i;
        if (r_mm.load) begin
            w_wb_data = dmem_rdata;
        end else begin
            case (r_mm.dtype)
                DT_P:    w_wb_data = {31'd0, r_mm.res_p};
                DT_F:    w_wb_data = r_mm.res_f;
                default: w_wb_data = r_mm.res_i;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_dtype <= '0;
            r_wb_dest  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_retire & r_mm.wb_en & ~r_mm.store & ~w_fault;
            if (w_retire) begin
                r_wb_dtype <= r_mm.dtype;
                r_wb_dest  <= r_mm_dest;
                r_wb_data  <= w_wb_data;
            end
        end
    end

    // ---------------- Outputs ----------------
    // Forwarding never carries load data; load-use is stalled upstream.
    assign pval_mm   = r_mm.res_p;
    assign rval_mm   = r_mm.res_i;
    assign fval_mm   = r_mm.res_f;
    assign mm_busy   = w_busy;
    assign mem_fault = w_fault;
    assign wb_valid  = r_wb_valid;
    assign wb_dtype  = r_wb_dtype;
    assign wb_dest   = r_wb_dest;
    assign wb_data   = r_wb_data;

endmodule
